// File: rtl/feistel_sbox_stage.sv
// -----------------------------------------------------------------------------
// feistel_sbox_stage
//
// Multi-cycle DES S-box substitution stage of the Feistel round function.
// The E-expanded right half is XORed with the round subkey when an operand is
// accepted. S1..S8 are then evaluated SBOX_PER_CYCLE boxes per clock, so the
// stage takes NSTEP = 8/SBOX_PER_CYCLE cycles. The 32-bit result is held
// until the downstream P-box stage takes it. With SBOX_PER_CYCLE=1 all eight
// boxes share a single 6->4 lookup path.
//
// Bit numbering: index 0 of every bus is DES bit 1 (the DES MSB).
//
// Ports
//   wClk           in   1   clock, all state on the rising edge
//   wReset         in   1   asynchronous, active-high reset
//   wInValid       in   1   upstream presents wExpandedData / wRoundKey
//   wInReady       out  1   stage can accept an operand this cycle
//   wExpandedData  in   48  E-expanded right half
//   wRoundKey      in   48  round subkey
//   wOutValid      out  1   wOutputData holds a completed result
//   wOutReady      in   1   downstream accepts the result
//   wOutputData    out  32  S-box output
//   wBusy          out  1   high while boxes are being evaluated (RUN)
// -----------------------------------------------------------------------------
module feistel_sbox_stage #(
  parameter int SBOX_PER_CYCLE = 1
) (
  input  logic        wClk,
  input  logic        wReset,
  input  logic        wInValid,
  output logic        wInReady,
  input  logic [47:0] wExpandedData,
  input  logic [47:0] wRoundKey,
  output logic        wOutValid,
  input  logic        wOutReady,
  output logic [31:0] wOutputData,
  output logic        wBusy
);

  localparam int NSTEP = 8 / SBOX_PER_CYCLE;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

  if (!(SBOX_PER_CYCLE == 1 || SBOX_PER_CYCLE == 2 ||
        SBOX_PER_CYCLE == 4 || SBOX_PER_CYCLE == 8)) begin : g_bad_param
    $error("feistel_sbox_stage: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
  end

  // ---------------------------------------------------------------------------
  // S-box ROM (FIPS 46-3 S1..S8). Each entry is one box; the 64 nibbles are
  // laid out row-major (row 0 col 0 first, i.e. in the most significant
  // nibble), so the hex text reads exactly like the published tables.
  // ---------------------------------------------------------------------------
  localparam logic [255:0] SBOX_ROM [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D, // S1
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9, // S2
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C, // S3
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E, // S4
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453, // S5
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D, // S6
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C, // S7
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B  // S8
  };

  // six[0] is the first DES bit of the group. Row = {six[0], six[5]},
  // column = {six[1], six[2], six[3], six[4]}; together they form the
  // row-major table address row*16+col.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box,
                                             input logic [5:0] six);
    logic [5:0]   addr;
    logic [255:0] rom;
    addr = {six[0], six[5], six[1], six[2], six[3], six[4]};
    rom  = SBOX_ROM[box];
    // Entry addr sits at bits [255-4*addr -: 4]; 255-4*addr == {~addr, 2'b11}.
    return rom[{~addr, 2'b11} -: 4];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [47:0]       operand_q, operand_d;
  logic [3:0]        res_q [8];
  logic [3:0]        res_d [8];
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic              last_step;

  logic [5:0]        chunk    [8];
  logic [2:0]        lane_box [SBOX_PER_CYCLE];
  logic [3:0]        lane_nib [SBOX_PER_CYCLE];

  // ---------------------------------------------------------------------------
  // Lookup lanes
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 8; gi++) begin : g_chunk
    assign chunk[gi] = operand_q[6*gi +: 6];
  end

  // Lane gi handles box cnt*SBOX_PER_CYCLE+gi in the current step. The 4-bit
  // S-box value is stored bit-reversed so its MSB lands on the lower index.
  for (genvar gi = 0; gi < SBOX_PER_CYCLE; gi++) begin : g_lane
    logic [3:0] val;
    assign lane_box[gi] = 3'((int'(cnt_q) * SBOX_PER_CYCLE) + gi);
    assign val          = sbox_lookup(lane_box[gi], chunk[lane_box[gi]]);
    assign lane_nib[gi] = {val[0], val[1], val[2], val[3]};
  end

  assign accept    = wInValid & wInReady;
  assign last_step = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge wClk or posedge wReset) begin
    if (wReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wInValid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_step) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // A new operand taken in the same cycle as the result avoids a bubble.
        if (wOutReady) state_d = wInValid ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. wInReady in HOLD follows wOutReady combinationally, which is
  // the only direct input-to-output path of the stage.
  // ---------------------------------------------------------------------------
  always_comb begin
    wInReady = 1'b0;
    wBusy    = 1'b0;
    case (state_q)
      ST_IDLE: wInReady = 1'b1;
      ST_RUN:  wBusy    = 1'b1;
      ST_HOLD: wInReady = wOutReady;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    operand_d  = operand_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    out_data_d = out_data_q;

    if (state_q == ST_RUN) begin
      for (int i = 0; i < SBOX_PER_CYCLE; i++) begin
        res_d[lane_box[i]] = lane_nib[i];
      end
      cnt_d = last_step ? '0 : cnt_q + CNT_W'(1);
      // The visible result is only refreshed once every box has been written,
      // so a partially updated word is never presented.
      if (last_step) begin
        for (int j = 0; j < 8; j++) begin
          out_data_d[4*j +: 4] = res_d[j];
        end
      end
    end

    if (accept) begin
      operand_d = wExpandedData ^ wRoundKey;
      cnt_d     = '0;
    end
  end

  assign out_valid_d = (state_d == ST_HOLD);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wClk or posedge wReset) begin
    if (wReset) begin
      cnt_q       <= '0;
      operand_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      operand_q   <= operand_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 8; i++) begin
        res_q[i] <= res_d[i];
      end
    end
  end

  assign wOutValid   = out_valid_q;
  assign wOutputData = out_data_q;

endmodule
